div_seq_ctrl: RTL and testbench

Sequencing controller between the chip's byte-serial pins and the SRT radix-2 divider core. It assembles eight pushed bytes into a 32-bit dividend and a 32-bit divisor and starts the core. It waits for completion, then streams the 64-bit remainder/quotient result back out as eight bytes behind a frame marker. Integer divide-by-zero and signed overflow are resolved locally without starting the core.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_byte_serializer.sv | 69 ++++++
 rtl/div_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_pkg: shared state encoding and result constants for the divider        |
// | byte-serial sequencing controller.                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // State encoding of the sequencing FSM
  typedef logic [2:0] div_state_t;
  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;
  localparam logic [DIV_WIDTH-1:0] SOVF_QUOT = 32'h8000_0000;

  localparam int ERR_W       = 2;
  localparam int ERR_OVERRUN = 0;
  localparam int ERR_TIMEOUT = 1;

endpackage
`default_nettype wire

// File: rtl/div_byte_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_byte_serializer: frame marker followed by the remainder then quotient, |
// | least significant byte first.                                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_byte_serializer
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] rem,
  output logic [7:0]       data_out,
  output logic             pull,
  output logic             active,
  output logic             last
);

  localparam int c_nbytes = (2 * WIDTH) / 8;
  localparam int c_cnt_w  = $clog2(c_nbytes + 1);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_nbytes);

  logic [2*WIDTH-1:0] r_shift;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_active;
  logic               r_pull;
  logic [7:0]         r_data;
  logic               w_last;

  assign w_last   = r_active && (r_cnt == c_last_cnt);
  assign data_out = r_data;
  assign pull     = r_pull;
  assign active   = r_active;
  assign last     = w_last;

  // Count 0 is the marker cycle; each later cycle exposes the next low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_pull   <= 1'b0;
      r_data   <= '0;
    end else if (load) begin
      r_shift  <= {quot, rem};
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_pull   <= 1'b1;
      r_data   <= '0;
    end else if (r_active) begin
      r_pull <= 1'b0;
      if (w_last) begin
        r_active <= 1'b0;
        r_data   <= '0;
        r_cnt    <= '0;
      end else begin
        r_data  <= r_shift[7:0];
        r_shift <= r_shift >> 8;
        r_cnt   <= r_cnt + c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_seq_ctrl: collects operand bytes, resolves trivial integer cases,      |
// | runs the SRT divider core and streams the result back out.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in_in,
  input  logic             push_in,
  input  logic             sign,
  input  logic             select,
  output logic [7:0]       data_out_out,
  output logic             pull_out,
  output logic             sign_out,
  output logic             busy,
  output logic [1:0]       err_flags,
  output logic             core_start,
  output logic             core_sign,
  output logic             core_select,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_quot,
  input  logic [WIDTH-1:0] core_rem
);

  localparam int NBYTES     = WIDTH / 8;
  localparam int c_op_bytes = 2 * NBYTES;
  localparam int c_cnt_w    = $clog2(c_op_bytes);
  localparam int c_wait_w   = $clog2(WAIT_MAX + 1);

  localparam logic [c_cnt_w-1:0]  c_last_byte = c_cnt_w'(c_op_bytes - 1);
  localparam logic [c_wait_w-1:0] c_wait_max  = c_wait_w'(WAIT_MAX);
  localparam logic [WIDTH-1:0]    c_int_min   = {SOVF_QUOT[DIV_WIDTH-1], {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]    c_div0_quot = {WIDTH{DIV0_QUOT[0]}};

  div_state_t           r_state;
  div_state_t           w_next_state;
  logic [c_cnt_w-1:0]   r_count;
  logic [2*WIDTH-1:0]   r_ops;
  logic                 r_sign;
  logic                 r_select;
  logic                 r_core_start;
  logic [c_wait_w-1:0]  r_wait_cnt;
  logic [c_wait_w-1:0]  w_wait_next;
  logic [ERR_W-1:0]     r_err;

  logic                 w_push_ok;
  logic                 w_last_push;
  logic [WIDTH-1:0]     w_dividend;
  logic [WIDTH-1:0]     w_divisor;
  logic                 w_div0;
  logic                 w_sovf;
  logic                 w_timeout;
  logic                 w_load;
  logic [WIDTH-1:0]     w_res_quot;
  logic [WIDTH-1:0]     w_res_rem;
  logic                 w_ser_active;
  logic                 w_ser_last;

  assign w_push_ok   = push_in && (r_state == ST_COLLECT);
  assign w_last_push = w_push_ok && (r_count == c_last_byte);
  assign w_dividend  = r_ops[2*WIDTH-1:WIDTH];
  assign w_divisor   = r_ops[WIDTH-1:0];
  assign w_div0      = !r_select && (w_divisor == '0);
  assign w_sovf      = !r_select && r_sign && (w_dividend == c_int_min) && (w_divisor == '1);
  assign w_wait_next = r_wait_cnt + c_wait_w'(1);
  // A completion in the final budgeted cycle takes priority over the timeout.
  assign w_timeout   = (r_state == ST_WAIT) && !core_done && (w_wait_next == c_wait_max);

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_res_quot   = '0;
    w_res_rem    = '0;
    case (r_state)
      ST_COLLECT: begin
        if (w_last_push) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_div0) begin
          w_load       = 1'b1;
          w_res_quot   = c_div0_quot;
          w_res_rem    = w_dividend;
          w_next_state = ST_SEND;
        end else if (w_sovf) begin
          w_load       = 1'b1;
          w_res_quot   = c_int_min;
          w_next_state = ST_SEND;
        end else begin
          w_next_state = ST_START;
        end
      end
      ST_START: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          w_load       = 1'b1;
          w_res_quot   = core_quot;
          w_res_rem    = core_rem;
          w_next_state = ST_SEND;
        end else if (w_timeout) begin
          w_load       = 1'b1;
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_ser_last) w_next_state = ST_COLLECT;
      end
      default: w_next_state = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_COLLECT;
      r_count      <= '0;
      r_ops        <= '0;
      r_sign       <= 1'b0;
      r_select     <= 1'b0;
      r_core_start <= 1'b0;
      r_wait_cnt   <= '0;
      r_err        <= '0;
    end else begin
      r_state      <= w_next_state;
      // Registered so the start pulse is a clean flop output for exactly START.
      r_core_start <= (w_next_state == ST_START);
      r_wait_cnt   <= (r_state == ST_WAIT) ? w_wait_next : '0;
      if (w_push_ok) begin
        r_ops   <= {r_ops[2*WIDTH-9:0], data_in_in};
        r_count <= w_last_push ? '0 : (r_count + c_cnt_w'(1));
        if (r_count == '0) begin
          r_sign   <= sign;
          r_select <= select;
        end
      end
      if (push_in && (r_state != ST_COLLECT)) r_err[ERR_OVERRUN] <= 1'b1;
      if (w_timeout) r_err[ERR_TIMEOUT] <= 1'b1;
    end
  end

  div_byte_serializer #(
    .WIDTH (WIDTH)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .quot     (w_res_quot),
    .rem      (w_res_rem),
    .data_out (data_out_out),
    .pull     (pull_out),
    .active   (w_ser_active),
    .last     (w_ser_last)
  );

  assign sign_out      = w_ser_active & r_sign;
  assign busy          = (r_state != ST_COLLECT);
  assign err_flags     = r_err;
  assign core_start    = r_core_start;
  assign core_sign     = r_sign;
  assign core_select   = r_select;
  assign core_dividend = w_dividend;
  assign core_divisor  = w_divisor;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_seq_ctrl: vector table with a result scoreboard and a behavioural   |
// | divider core with programmable latency.                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in_in;
  logic        push_in;
  logic        sign;
  logic        select;
  logic [7:0]  data_out_out;
  logic        pull_out;
  logic        sign_out;
  logic        busy;
  logic [1:0]  err_flags;
  logic        core_start;
  logic        core_sign;
  logic        core_select;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic        core_done;
  logic [31:0] core_quot;
  logic [31:0] core_rem;

  div_seq_ctrl #(.WIDTH(32), .WAIT_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n), .data_in_in(data_in_in), .push_in(push_in),
    .sign(sign), .select(select), .data_out_out(data_out_out), .pull_out(pull_out),
    .sign_out(sign_out), .busy(busy), .err_flags(err_flags), .core_start(core_start),
    .core_sign(core_sign), .core_select(core_select), .core_dividend(core_dividend),
    .core_divisor(core_divisor), .core_done(core_done), .core_quot(core_quot),
    .core_rem(core_rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd, dvs;
    logic        sgn, sel;
    logic        core_en;
    int          lat;
    logic [31:0] cq, cr;
    logic [31:0] eq, er;
    int          elat;
    int          estarts;
    logic        ovr;
    logic [1:0]  eerr;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        sgn;
    int          push_cyc;
    int          lat;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   starts = 0;
  sb_t  sb[$];
  vec_t vecs[12];

  logic [31:0] cm_q, cm_r, cm_dvd, cm_dvs;
  logic        cm_en, cm_sgn, cm_sel;
  int          cm_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] dvd, input logic [31:0] dvs,
                              input logic sgn, input logic sel, input logic en, input int lat,
                              input logic [31:0] cq, input logic [31:0] cr,
                              input logic [31:0] eq, input logic [31:0] er,
                              input int elat, input int estarts, input logic ovr,
                              input logic [1:0] eerr);
    vec_t v;
    v.dvd = dvd; v.dvs = dvs; v.sgn = sgn; v.sel = sel; v.core_en = en; v.lat = lat;
    v.cq = cq; v.cr = cr; v.eq = eq; v.er = er; v.elat = elat; v.estarts = estarts;
    v.ovr = ovr; v.eerr = eerr;
    return v;
  endfunction

  // Behavioural divider core: responds cm_lat cycles after the start pulse.
  initial begin
    core_done = 1'b0; core_quot = '0; core_rem = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        starts++;
        chk("core_dividend", 64'(core_dividend), 64'(cm_dvd));
        chk("core_divisor", 64'(core_divisor), 64'(cm_dvs));
        chk("core_sign", 64'(core_sign), 64'(cm_sgn));
        chk("core_select", 64'(core_select), 64'(cm_sel));
        if (cm_en) begin
          repeat (cm_lat) @(posedge clk);
          #1;
          core_done = 1'b1; core_quot = cm_q; core_rem = cm_r;
          @(posedge clk);
          #1;
          core_done = 1'b0; core_quot = '0; core_rem = '0;
        end
      end
    end
  end

  // Frame monitor: collects 8 bytes after each marker and scores them.
  int          mon_phase = 0;
  int          pull_cyc = 0;
  logic [63:0] mon_bytes = '0;
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      mon_phase = 0;
    end else if (mon_phase == 0) begin
      if (pull_out) begin
        pull_cyc  = cyc;
        mon_phase = 1;
        chk("marker_data_zero", 64'(data_out_out), 64'd0);
        if (sb.size() > 0) chk("sign_out_marker", 64'(sign_out), 64'(sb[0].sgn));
      end
    end else begin
      mon_bytes = {data_out_out, mon_bytes[63:8]};
      chk("pull_low_in_payload", 64'(pull_out), 64'd0);
      if (sb.size() > 0) chk("sign_out_payload", 64'(sign_out), 64'(sb[0].sgn));
      if (mon_phase == 8) begin
        mon_phase = 0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: got %0h expected no frame", mon_bytes);
        end else begin
          e = sb.pop_front();
          chk("result_bytes", mon_bytes, e.res);
          chk("pull_latency", 64'(pull_cyc - e.push_cyc), 64'(e.lat));
        end
      end else begin
        mon_phase++;
      end
    end
  end

  // Called at posedge+1; the byte is sampled at the following posedge.
  task automatic push_byte(input logic [7:0] b, input logic s, input logic sel);
    data_in_in = b; sign = s; select = sel; push_in = 1'b1;
    @(posedge clk);
    #1;
    push_in = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [63:0] ops;
    sb_t         e;
    int          s0;
    int          k;
    cm_q = v.cq; cm_r = v.cr; cm_lat = v.lat; cm_en = v.core_en;
    cm_dvd = v.dvd; cm_dvs = v.dvs; cm_sgn = v.sgn; cm_sel = v.sel;
    s0  = starts;
    ops = {v.dvd, v.dvs};
    // Later bytes carry inverted sign/select so only push 0 may be latched.
    for (int i = 0; i < 8; i++)
      push_byte(ops[63-8*i -: 8], (i == 0) ? v.sgn : ~v.sgn, (i == 0) ? v.sel : ~v.sel);
    e.res = {v.eq, v.er}; e.sgn = v.sgn; e.push_cyc = cyc - 1; e.lat = v.elat;
    sb.push_back(e);
    if (v.ovr) begin
      repeat (2) @(posedge clk);
      #1;
      push_byte(8'hAA, 1'b1, 1'b1);
      @(negedge clk);
      chk({tag, "_overrun_flag"}, 64'(err_flags[0]), 64'd1);
    end
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_completed"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_frame_seen"}, 64'(sb.size()), 64'd0);
    sb.delete();
    chk({tag, "_core_starts"}, 64'(starts - s0), 64'(v.estarts));
    chk({tag, "_err_flags"}, 64'(err_flags), 64'(v.eerr));
    chk({tag, "_idle_data"}, 64'({data_out_out, sign_out, pull_out}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; push_in = 1'b0; data_in_in = '0; sign = 1'b0; select = 1'b0;
    cm_q = '0; cm_r = '0; cm_lat = 1; cm_en = 1'b0;
    cm_dvd = '0; cm_dvs = '0; cm_sgn = 1'b0; cm_sel = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pull", 64'(pull_out), 64'd0);
    chk("rst_data", 64'(data_out_out), 64'd0);
    chk("rst_err", 64'(err_flags), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_operands", {core_dividend, core_divisor}, 64'd0);
    chk("rst_sign_out", 64'(sign_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vecs[0]  = mk(32'd100, 32'd7, 0, 0, 1, 5, 32'd14, 32'd2, 32'd14, 32'd2, 8, 1, 0, 2'b00);
    vecs[1]  = mk(32'h1234_5678, 32'h0, 0, 0, 1, 5, 0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 2, 0, 0, 2'b00);
    vecs[2]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1, 5, 0, 0, 32'h8000_0000, 32'h0, 2, 0, 0, 2'b00);
    vecs[3]  = mk(32'hFFFF_FF9C, 32'd7, 1, 0, 1, 3, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 6, 1, 0, 2'b00);
    vecs[4]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 1, 32'h0, 32'h8000_0000, 32'h0, 32'h8000_0000, 4, 1, 0, 2'b00);
    vecs[5]  = mk(32'h3F80_0000, 32'h0, 0, 1, 1, 4, 32'h7F80_0000, 32'h0, 32'h7F80_0000, 32'h0, 7, 1, 0, 2'b00);
    vecs[6]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 1, 2, 32'h1111_1111, 32'h0, 32'h1111_1111, 32'h0, 5, 1, 0, 2'b00);
    vecs[7]  = mk(32'h0, 32'h0, 1, 0, 1, 5, 0, 0, 32'hFFFF_FFFF, 32'h0, 2, 0, 0, 2'b00);
    vecs[8]  = mk(32'd100, 32'd7, 0, 0, 1, 5, 32'd14, 32'd2, 32'd14, 32'd2, 8, 1, 1, 2'b01);
    vecs[9]  = mk(32'd100, 32'd7, 0, 0, 1, 5, 32'd14, 32'd2, 32'd14, 32'd2, 8, 1, 0, 2'b01);
    vecs[10] = mk(32'd55, 32'd3, 0, 0, 1, 255, 32'h11, 32'h22, 32'h11, 32'h22, 258, 1, 0, 2'b01);
    vecs[11] = mk(32'd55, 32'd3, 0, 0, 0, 0, 32'h11, 32'h22, 32'h0, 32'h0, 258, 1, 0, 2'b11);

    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a divide-by-zero frame.
    for (int i = 0; i < 8; i++) push_byte((i < 4) ? 8'(32'h1234_5678 >> (24 - 8*i)) : 8'h00, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    chk("send4_byte", 64'(data_out_out), 64'h12);
    rst_n = 1'b0;
    #1;
    chk("arst_pull", 64'(pull_out), 64'd0);
    chk("arst_data", 64'(data_out_out), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_err", 64'(err_flags), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(vecs[0], "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
